// File: rtl/mazesolver_keyled_io.sv
// Avalon-MM key/LED peripheral: synchronised, debounced keys with press capture and IRQ; LED drive.
// Optional hardware blink (LED_BLINK, BLINK_HALF, blink counter) is built when KEYLED_BLINK_EN is defined.
module mazesolver_keyled_io #(
  parameter int NUM_KEYS        = 3,
  parameter int NUM_LEDS        = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                avs_chipselect,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_LEDS-1:0] led
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bus semantics: a transfer happens on every clock edge where avs_chipselect is high with
  // avs_read or avs_write; there is no waitrequest, and read data appears on the edge after the
  // read and holds until the next read.
  logic wr_en, rd_en;
  assign wr_en = avs_chipselect & avs_write;
  assign rd_en = avs_chipselect & avs_read;

  logic [NUM_KEYS-1:0] sync_0, sync_1, key_sync, key_state, key_rise, edge_cap, irq_mask, w1c;
  logic [CW-1:0]       db_cnt [NUM_KEYS];
  logic [NUM_LEDS-1:0] led_out, led_next;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Synchroniser flops idle at 1 so that a released key (high) reads as not pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_0 <= '1;
      sync_1 <= '1;
    end else begin
      sync_0 <= key_n;
      sync_1 <= sync_0;
    end
  end
  assign key_sync = ~sync_1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_state <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sync[i] == key_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          key_state[i] <= key_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press event is the same-edge transition of the stable level from 0 to 1.
  always_comb begin
    key_rise = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_rise[i] = key_sync[i] & ~key_state[i] & (db_cnt[i] == DB_LAST);
  end

  assign w1c = (wr_en && avs_address == 3'd1) ? avs_writedata[NUM_KEYS-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      led_out  <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | key_rise;
      if (wr_en && avs_address == 3'd2) irq_mask <= avs_writedata[NUM_KEYS-1:0];
      if (wr_en && avs_address == 3'd3) led_out  <= avs_writedata[NUM_LEDS-1:0];
      irq <= |(edge_cap & irq_mask);
    end
  end

`ifdef KEYLED_BLINK_EN
  logic [NUM_LEDS-1:0] led_blink;
  logic [31:0]         blink_half, blink_cnt;
  logic                phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_blink  <= '0;
      blink_half <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      if (wr_en && avs_address == 3'd4) led_blink <= avs_writedata[NUM_LEDS-1:0];
      if (wr_en && avs_address == 3'd5) begin
        blink_half <= avs_writedata;
        blink_cnt  <= '0;
        phase      <= 1'b1;
      end else if (blink_half == 32'd0) begin
        phase <= 1'b1;
      end else if (blink_cnt == blink_half - 32'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

  assign led_next = led_out & (~led_blink | {NUM_LEDS{phase}});
`else
  assign led_next = led_out;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux = 32'(key_state);
      3'd1: rd_mux = 32'(edge_cap);
      3'd2: rd_mux = 32'(irq_mask);
      3'd3: rd_mux = 32'(led_out);
`ifdef KEYLED_BLINK_EN
      3'd4: rd_mux = 32'(led_blink);
      3'd5: rd_mux = blink_half;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      led          <= '0;
    end else begin
      if (rd_en) avs_readdata <= rd_mux;
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_mazesolver_keyled_io.sv
// Bench for mazesolver_keyled_io with a short debounce; read results go through an expected queue.
module tb_mazesolver_keyled_io;
  localparam int NK = 3;
  localparam int NL = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          avs_chipselect = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [NK-1:0] key_n = '1;
  logic [NL-1:0] led;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];

  mazesolver_keyled_io #(.NUM_KEYS(NK), .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .avs_chipselect(avs_chipselect), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .irq(irq), .key_n(key_n), .led(led)
  );

  always #5 clk = ~clk;

  // ---- driver tasks (all return 1 time unit after a rising edge) ----
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    logic [31:0] x;
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    exp_q.push_back(e);
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    x = exp_q.pop_front();
    chk_cnt++;
    if (avs_readdata !== x) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, avs_readdata, x);
    else pass_cnt++;
  endtask

  // ---- tests ----
  task automatic test_reset();
    reset_n = 1'b0; key_n = '1;
    cyc(3);
    chk_cnt++;
    if (led !== 8'h00 || irq !== 1'b0 || avs_readdata !== 32'h0)
      $display("FAIL reset_outputs: led=%h irq=%b rdata=%h expected 0/0/0", led, irq, avs_readdata);
    else pass_cnt++;
    reset_n = 1'b1;
    cyc(1);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("reset_read_addr%0d", a));
  endtask

  task automatic test_debounce();
    logic [31:0] x;
    key_n[1] = 1'b0; cyc(10); key_n[1] = 1'b1;
    cyc(25);
    rd(3'd0, 32'h0, "glitch_key_state");
    rd(3'd1, 32'h0, "glitch_edge_cap");
    // Continuous reads of KEY_STATE; data after edge k shows the stable level after edge k-1.
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 3'd0;
    key_n[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back((k >= DB + 3) ? 32'h2 : 32'h0);
      cyc(1);
      x = exp_q.pop_front();
      chk_cnt++;
      if (avs_readdata !== x)
        $display("FAIL press_timing_edge%0d: got 0x%08h expected 0x%08h", k, avs_readdata, x);
      else pass_cnt++;
    end
    avs_chipselect = 1'b0; avs_read = 1'b0;
    rd(3'd1, 32'h2, "press_edge_cap");
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL masked_irq: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_interrupt();
    key_n[1] = 1'b1; cyc(25);
    rd(3'd1, 32'h2, "release_keeps_cap");
    wr(3'd1, 32'h2);
    rd(3'd1, 32'h0, "w1c_clear");
    wr(3'd2, 32'h2);
    rd(3'd2, 32'h2, "irq_mask_rb");
    cyc(1);
    chk_cnt++;
    if (avs_readdata !== 32'h2) $display("FAIL readdata_hold: got 0x%08h expected 0x00000002", avs_readdata);
    else pass_cnt++;
    key_n[1] = 1'b0; cyc(25);
    rd(3'd1, 32'h2, "irq_edge_cap");
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_assert: got %b expected 1", irq);
    else pass_cnt++;
    wr(3'd1, 32'h2);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_w1c_1cyc: got %b expected 1", irq);
    else pass_cnt++;
    cyc(1);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_w1c_2cyc: got %b expected 0", irq);
    else pass_cnt++;
    key_n[1] = 1'b1; cyc(25);
    rd(3'd1, 32'h0, "release_no_edge");
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_after_release: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    key_n[0] = 1'b0;
    cyc(DB + 1);
    // The stable level of key 0 rises on the next edge, together with this W1C.
    wr(3'd1, 32'h1);
    rd(3'd1, 32'h1, "set_beats_clear");
    rd(3'd0, 32'h1, "key0_state");
    wr(3'd1, 32'h1);
    rd(3'd1, 32'h0, "clear_after_set");
    key_n[0] = 1'b1; cyc(25);
    rd(3'd0, 32'h0, "key0_released");
  endtask

  task automatic test_led();
    wr(3'd3, 32'h000000A5);
    chk_cnt++;
    if (led !== 8'h00) $display("FAIL led_before_latency: got %h expected 00", led);
    else pass_cnt++;
    cyc(1);
    chk_cnt++;
    if (led !== 8'hA5) $display("FAIL led_after_write: got %h expected a5", led);
    else pass_cnt++;
    rd(3'd3, 32'hA5, "led_out_rb");
  endtask

`ifdef KEYLED_BLINK_EN
  task automatic test_blink();
    logic [NL-1:0] e;
    wr(3'd3, 32'hFF);
    wr(3'd4, 32'h0F);
    wr(3'd5, 32'd4);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      e = (((k - 1) / 4) % 2 == 0) ? 8'hFF : 8'hF0;
      chk_cnt++;
      if (led !== e) $display("FAIL blink_k%0d: got %h expected %h", k, led, e);
      else pass_cnt++;
    end
    rd(3'd4, 32'h0F, "blink_en_rb");
    rd(3'd5, 32'h4, "blink_half_rb");
    wr(3'd5, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk_cnt++;
      if (led !== 8'hFF) $display("FAIL blink_off_k%0d: got %h expected ff", k, led);
      else pass_cnt++;
    end
  endtask
`else
  task automatic test_blink();
    wr(3'd3, 32'h3C);
    wr(3'd4, 32'h0F);
    rd(3'd4, 32'h0, "blink_en_absent");
    wr(3'd5, 32'd4);
    rd(3'd5, 32'h0, "blink_half_absent");
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk_cnt++;
      if (led !== 8'h3C) $display("FAIL led_static_k%0d: got %h expected 3c", k, led);
      else pass_cnt++;
    end
  endtask
`endif

  task automatic test_async_reset();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h7);
    key_n[2] = 1'b0;
    cyc(8);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (led !== 8'h00 || irq !== 1'b0 || avs_readdata !== 32'h0)
      $display("FAIL async_reset: led=%h irq=%b rdata=%h expected 0/0/0", led, irq, avs_readdata);
    else pass_cnt++;
    key_n = '1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(25);
    rd(3'd0, 32'h0, "post_reset_key_state");
    rd(3'd2, 32'h0, "post_reset_mask");
    rd(3'd3, 32'h0, "post_reset_led_out");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_interrupt();
    test_simultaneous();
    test_led();
    test_blink();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
